immediate_extender_pipe: RTL
============================

# immediate_extender_pipe

Parametrised, registered immediate extender for the miniMIPS datapath. Takes an `IN_W`-bit immediate field plus an extension mode and delivers an `OUT_W`-bit operand through a valid/ready interface. A 2-entry skid buffer preserves order and absorbs one cycle of downstream stall without a combinational ready path. It sits between instruction decode and the ALU/branch-target operand mux, replacing the purely combinational extender.

## Interface

Parameters:
- `IN_W`, 6, width of the incoming immediate field; must satisfy `IN_W + 2 <= OUT_W`.
- `OUT_W`, 32, width of the extended operand.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream holds a valid immediate.
- `in_ready`  output  1  block can accept this cycle.
- `immed`  input  IN_W  raw immediate field.
- `mode`  input  2  00 sign-extend, 01 zero-extend, 10 sign-extend then shift left 2, 11 upper-place (see Configuration).
- `out_valid`  output  1  `immed_out` holds a valid result.
- `out_ready`  input  1  downstream accepts this cycle.
- `immed_out`  output  OUT_W  extended operand.

## Operation

- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Extension is computed combinationally from `immed` and `mode` at push time; only the result is stored, never the raw field.
- Mode 00: replicate `immed[IN_W-1]` into bits `OUT_W-1..IN_W`.
- Mode 01: bits `OUT_W-1..IN_W` = 0.
- Mode 10: sign-extend to `OUT_W`, shift left 2, discard top 2 bits, bits 1..0 = 0 (branch offset).
- Mode 11: described under Configuration.
- Storage: output register `R0` drives `immed_out`; skid register `R1`.
- State machine (encoded by occupancy):
  - EMPTY: push -> ONE, result into R0.
  - ONE: push only -> TWO, result into R1. Pop only -> EMPTY. Push and pop -> stay ONE, new result into R0.
  - TWO: push impossible (`in_ready`=0). Pop -> ONE, R1 moves to R0.
- `out_valid` = (state != EMPTY). `in_ready` = (state != TWO) && !reset.
- Strict FIFO order; no result dropped or duplicated.
- `immed_out` stays stable while `out_valid` && !`out_ready`.

## Timing

- Reset (sampled high at an edge): state EMPTY, `out_valid`=0, `immed_out`=0, R1=0. `in_ready`=0 while `reset` is high, 1 from the first cycle after release.
- Reset mid-operation flushes both entries the same edge; pending data is lost; pushes on that edge are ignored.
- Latency: push at edge N -> `out_valid`=1 and correct `immed_out` after edge N, i.e. visible in cycle N+1.
- Throughput: 1 result per cycle with `out_ready` held high.
- `in_ready` depends only on registered state, never on `out_ready` in the same cycle.
- Stall: with `out_ready`=0, at most 2 pushes are accepted; `in_ready` falls the cycle after the second push.
- `in_valid` high with `in_ready` low: no effect; upstream must hold data.

## Configuration

- Macro `IMM_EXT_UPPER_EN`.
- Defined: mode 11 places `immed` in bits `OUT_W-1..OUT_W-IN_W`; lower bits = 0 (LUI-style upper immediate).
- Undefined: upper-place logic is not built; mode 11 behaves exactly as mode 00 (sign-extend).

## Test plan

- Reset, then push `immed`=6'b100010 mode 00 with `out_ready`=1 -> next cycle `out_valid`=1, `immed_out`=32'hFFFFFFE2; push mode 01 -> 32'h00000022.
- Push 6'b111111 mode 10 -> 32'hFFFFFFFC. Push 6'b011010 mode 10 -> 32'h00000068.
- Push 6'b000011 mode 11: with `IMM_EXT_UPPER_EN` -> 32'h0C000000; without -> 32'h00000003.
- `out_ready`=0, offer 000010, 000011, 011010 back-to-back -> first two accepted, `in_ready`=0 afterwards. Raise `out_ready` -> outputs 32'h2, 32'h3, then 32'h1A accepted and output, in order.
- Continuous `in_valid` and `out_ready` for 8 cycles with incrementing `immed` in mode 01 -> 8 results on consecutive cycles; state never reaches TWO.
- Fill to TWO, assert `reset` for one cycle -> `out_valid`=0, `immed_out`=0, `in_ready`=0 during reset, 1 the cycle after; no stale results appear.

Source files
------------

// File: rtl/immediate_extender_pipe.sv
// Registered immediate extender with a 2-entry skid buffer on valid/ready.
// Optional IMM_EXT_UPPER_EN builds LUI-style upper placement for mode 11.
module immediate_extender_pipe #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  immed,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] immed_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] r0_q, r0_d;
  logic [OUT_W-1:0] r1_q, r1_d;
  logic [OUT_W-1:0] sext, zext, shl, ext;
  logic             push, pop;

  assign sext = {{(OUT_W-IN_W){immed[IN_W-1]}}, immed};
  assign zext = {{(OUT_W-IN_W){1'b0}}, immed};
  assign shl  = {sext[OUT_W-3:0], 2'b00};

  always_comb begin
    ext = sext;
    unique case (mode)
      2'b00: ext = sext;
      2'b01: ext = zext;
      2'b10: ext = shl;
`ifdef IMM_EXT_UPPER_EN
      2'b11: ext = {immed, {(OUT_W-IN_W){1'b0}}};
`else
      2'b11: ext = sext;
`endif
      default: ext = sext;
    endcase
  end

  assign in_ready  = (state_q != TWO) && !reset;
  assign out_valid = (state_q != EMPTY);
  assign immed_out = r0_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          r0_d    = ext;
        end
      end
      ONE: begin
        if (push && pop) begin
          r0_d = ext;
        end else if (push) begin
          state_d = TWO;
          r1_d    = ext;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          r0_d    = r1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      r0_q    <= '0;
      r1_q    <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
    end
  end

endmodule
